// File: rtl/mem_stage.sv
// Memory stage of the pipelined ARM core: E/M and M/W pipeline registers plus a
// req/ack data-memory handshake with a wait-cycle timeout and a sticky fault flag.
module mem_stage #(
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] FAULT_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [3:0]  RdE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    output logic        RegWriteM,
    output logic [3:0]  RdM,
    output logic [31:0] ALUResultM,
    output logic        stallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [3:0]  RdW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ReadDataW,
    output logic        mem_fault
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        stateQ, stateD;
    logic [CW-1:0] cntQ, cntD;

    logic          regWriteMQ, memtoRegMQ, memWriteMQ;
    logic [3:0]    rdMQ;
    logic [31:0]   aluResultMQ, writeDataMQ;

    logic          regWriteWQ, memtoRegWQ;
    logic [3:0]    rdWQ;
    logic [31:0]   aluOutWQ, readDataWQ;
    logic          faultQ;

    logic          memopM, ackOk, timeoutHit, complete;

    assign memopM     = memtoRegMQ | memWriteMQ;
    assign mem_req    = memopM & ((stateQ == S_IDLE) | (stateQ == S_WAIT)) & reset;
    assign ackOk      = mem_req & mem_ack;
    assign timeoutHit = (stateQ == S_WAIT) & ~mem_ack & (cntQ == TIMEOUT_C);
    assign complete   = ackOk | timeoutHit;
    assign stallM     = memopM & ~complete;

    assign mem_we     = memWriteMQ;
    assign mem_addr   = {aluResultMQ[31:2], 2'b00};
    assign mem_wdata  = writeDataMQ;

    assign RegWriteM  = regWriteMQ;
    assign RdM        = rdMQ;
    assign ALUResultM = aluResultMQ;
    assign RegWriteW  = regWriteWQ;
    assign MemtoRegW  = memtoRegWQ;
    assign RdW        = rdWQ;
    assign ALUOutW    = aluOutWQ;
    assign ReadDataW  = readDataWQ;
    assign mem_fault  = faultQ;

    // A same-cycle ack in IDLE is a zero-wait access; only a missing ack enters WAIT.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            S_IDLE: begin
                if (mem_req && !mem_ack) begin
                    stateD = S_WAIT;
                    cntD   = CNT_ONE;
                end
            end
            S_WAIT: begin
                if (mem_ack || cntQ == TIMEOUT_C) begin
                    stateD = S_IDLE;
                    cntD   = '0;
                end else begin
                    cntD = cntQ + CNT_ONE;
                end
            end
            default: begin
                stateD = S_IDLE;
                cntD   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ <= S_IDLE;
            cntQ   <= '0;
            faultQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (timeoutHit) faultQ <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regWriteMQ  <= 1'b0;
            memtoRegMQ  <= 1'b0;
            memWriteMQ  <= 1'b0;
            rdMQ        <= '0;
            aluResultMQ <= '0;
            writeDataMQ <= '0;
        end else if (!stallM) begin
            regWriteMQ  <= RegWriteE;
            memtoRegMQ  <= MemtoRegE;
            memWriteMQ  <= MemWriteE;
            rdMQ        <= RdE;
            aluResultMQ <= ALUResultE;
            writeDataMQ <= WriteDataE;
        end
    end

    // Stores and timed-out accesses never reach the register file.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regWriteWQ <= 1'b0;
            memtoRegWQ <= 1'b0;
            rdWQ       <= '0;
            aluOutWQ   <= '0;
            readDataWQ <= '0;
        end else if (stallM) begin
            regWriteWQ <= 1'b0;
            memtoRegWQ <= 1'b0;
        end else begin
            regWriteWQ <= regWriteMQ & ~memWriteMQ & ~timeoutHit;
            memtoRegWQ <= memtoRegMQ;
            rdWQ       <= rdMQ;
            aluOutWQ   <= aluResultMQ;
            if (memtoRegMQ && ackOk) begin
                readDataWQ <= mem_rdata;
            end else if (memtoRegMQ && timeoutHit) begin
                readDataWQ <= FAULT_DATA;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: a vector table of zero-wait traffic checked through a
// writeback scoreboard, plus hand-written wait-state, timeout and reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemtoRegE, MemWriteE;
    logic [3:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE;
    logic        RegWriteM;
    logic [3:0]  RdM;
    logic [31:0] ALUResultM;
    logic        stallM, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        RegWriteW, MemtoRegW;
    logic [3:0]  RdW;
    logic [31:0] ALUOutW, ReadDataW;
    logic        mem_fault;

    int checks = 0;
    int failures = 0;

    mem_stage #(.TIMEOUT(16), .FAULT_DATA(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RegWriteM(RegWriteM), .RdM(RdM), .ALUResultM(ALUResultM),
        .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .RdW(RdW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, m2r, mw;
        logic [3:0]  rd;
        logic [31:0] alu, wd, rdata;
        logic        expReq, expWe;
        logic [31:0] expAddr;
        logic        expRw, expM2r;
        logic [3:0]  expRd;
        logic [31:0] expAluOut, expRead;
    } vec_t;

    typedef struct {
        logic        rw, m2r;
        logic [3:0]  rd;
        logic [31:0] aluOut, read;
    } wexp_t;

    localparam int N = 7;
    vec_t  vecs[N];
    wexp_t wq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rw, input logic m2r, input logic mw,
                                 input logic [3:0] rd, input logic [31:0] alu,
                                 input logic [31:0] wd);
        RegWriteE  = rw;
        MemtoRegE  = m2r;
        MemWriteE  = mw;
        RdE        = rd;
        ALUResultE = alu;
        WriteDataE = wd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stallM"}, stallM, 0);
        checkOutput({tag, "_memReq"}, mem_req, 0);
        checkOutput({tag, "_RegWriteM"}, RegWriteM, 0);
        checkOutput({tag, "_ALUResultM"}, ALUResultM, 0);
        checkOutput({tag, "_RegWriteW"}, RegWriteW, 0);
        checkOutput({tag, "_MemtoRegW"}, MemtoRegW, 0);
        checkOutput({tag, "_RdW"}, RdW, 0);
        checkOutput({tag, "_ALUOutW"}, ALUOutW, 0);
        checkOutput({tag, "_ReadDataW"}, ReadDataW, 0);
        checkOutput({tag, "_memFault"}, mem_fault, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wexp_t e;
        int    stallCount;
        logic  done;

        // rw m2r mw rd alu wd rdata | req we addr | W: rw m2r rd aluOut read
        vecs[0] = '{1,0,0,4'd7, 32'h0000_0055, 32'h0, 32'h0,
                    0,0,32'h0000_0054, 1,0,4'd7, 32'h0000_0055, 32'h0};
        vecs[1] = '{1,1,0,4'd3, 32'h0000_1006, 32'h0, 32'hCAFE_F00D,
                    1,0,32'h0000_1004, 1,1,4'd3, 32'h0000_1006, 32'hCAFE_F00D};
        vecs[2] = '{1,1,0,4'd1, 32'h0000_0100, 32'h0, 32'h1111_1111,
                    1,0,32'h0000_0100, 1,1,4'd1, 32'h0000_0100, 32'h1111_1111};
        vecs[3] = '{1,1,0,4'd2, 32'h0000_0104, 32'h0, 32'h2222_2222,
                    1,0,32'h0000_0104, 1,1,4'd2, 32'h0000_0104, 32'h2222_2222};
        vecs[4] = '{1,0,1,4'd5, 32'h0000_0203, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                    1,1,32'h0000_0200, 0,0,4'd5, 32'h0000_0203, 32'h2222_2222};
        vecs[5] = '{0,0,0,4'hF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                    0,0,32'hFFFF_FFFC, 0,0,4'hF, 32'hFFFF_FFFF, 32'h2222_2222};
        vecs[6] = '{1,0,0,4'd0, 32'h8000_0000, 32'h0, 32'h0,
                    0,0,32'h8000_0000, 1,0,4'd0, 32'h8000_0000, 32'h2222_2222};

        reset = 1'b0;
        applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) tick();
        @(negedge clk);
        checkAllZero("reset");
        reset = 1'b1;

        // Zero-wait traffic: W results are queued when an instruction is seen in M.
        for (int c = 0; c < N + 2; c++) begin
            tick();
            if (c < N) applyStimulus(vecs[c].rw, vecs[c].m2r, vecs[c].mw,
                                     vecs[c].rd, vecs[c].alu, vecs[c].wd);
            else       applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0);
            mem_ack   = 1'b1;
            mem_rdata = (c >= 1 && c <= N) ? vecs[c-1].rdata : 32'h0;
            @(negedge clk);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                checkOutput("vecRegWriteW", RegWriteW, e.rw);
                checkOutput("vecMemtoRegW", MemtoRegW, e.m2r);
                checkOutput("vecRdW", RdW, e.rd);
                checkOutput("vecALUOutW", ALUOutW, e.aluOut);
                checkOutput("vecReadDataW", ReadDataW, e.read);
            end
            if (c >= 1 && c <= N) begin
                checkOutput("vecMemReq", mem_req, vecs[c-1].expReq);
                checkOutput("vecStallM", stallM, 0);
                checkOutput("vecALUResultM", ALUResultM, vecs[c-1].alu);
                if (vecs[c-1].expReq) begin
                    checkOutput("vecMemWe", mem_we, vecs[c-1].expWe);
                    checkOutput("vecMemAddr", mem_addr, vecs[c-1].expAddr);
                    if (vecs[c-1].expWe) checkOutput("vecMemWdata", mem_wdata, vecs[c-1].wd);
                end
                wq.push_back('{vecs[c-1].expRw, vecs[c-1].expM2r, vecs[c-1].expRd,
                               vecs[c-1].expAluOut, vecs[c-1].expRead});
            end
        end

        // Three-wait store with an ALU instruction waiting upstream.
        tick();
        applyStimulus(1, 0, 1, 4'd9, 32'h0000_0300, 32'h1234_5678);
        mem_ack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) applyStimulus(1, 0, 0, 4'd4, 32'h0000_0077, 32'h0);
            mem_ack = (k == 4);
            @(negedge clk);
            checkOutput("storeStallM", stallM, (k < 4) ? 32'd1 : 32'd0);
            checkOutput("storeMemReq", mem_req, 1);
            checkOutput("storeMemWe", mem_we, 1);
            checkOutput("storeMemWdata", mem_wdata, 32'h1234_5678);
            checkOutput("storeMemAddr", mem_addr, 32'h0000_0300);
            checkOutput("storeRegWriteW", RegWriteW, 0);
        end
        tick();
        applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0);
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("storeDoneRegWriteW", RegWriteW, 0);
        checkOutput("storeDoneRdW", RdW, 4'd9);
        checkOutput("storeDoneReadDataW", ReadDataW, 32'h2222_2222);
        checkOutput("aluAfterStoreRdM", RdM, 4'd4);
        checkOutput("aluAfterStoreMemReq", mem_req, 0);
        tick();
        @(negedge clk);
        checkOutput("aluAfterStoreRegWriteW", RegWriteW, 1);
        checkOutput("aluAfterStoreALUOutW", ALUOutW, 32'h0000_0077);

        // Load timeout with ack held low.
        tick();
        applyStimulus(1, 1, 0, 4'd6, 32'h0000_0200, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0);
        stallCount = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (stallM) begin
                stallCount++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checkOutput("timeoutReleased", done, 1);
        checkOutput("timeoutStallCycles", stallCount, 16);
        checkOutput("timeoutFaultBefore", mem_fault, 0);
        tick();
        @(negedge clk);
        checkOutput("timeoutRegWriteW", RegWriteW, 0);
        checkOutput("timeoutReadDataW", ReadDataW, 32'h0);
        checkOutput("timeoutRdW", RdW, 4'd6);
        checkOutput("timeoutFault", mem_fault, 1);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("timeoutFaultSticky", mem_fault, 1);

        // Reset arriving while a load sits in WAIT with counter=5.
        tick();
        applyStimulus(1, 1, 0, 4'd8, 32'h0000_0400, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0);
        repeat (4) tick();
        @(negedge clk);
        checkOutput("midWaitStallM", stallM, 1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetCycleMemReq", mem_req, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midReset");

        // Zero-wait load straight after reset shows the FSM is back in IDLE.
        tick();
        applyStimulus(1, 1, 0, 4'd3, 32'h0000_1006, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("postResetStallM", stallM, 0);
        checkOutput("postResetMemAddr", mem_addr, 32'h0000_1004);
        tick();
        @(negedge clk);
        checkOutput("postResetRegWriteW", RegWriteW, 1);
        checkOutput("postResetRdW", RdW, 4'd3);
        checkOutput("postResetReadDataW", ReadDataW, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the pipelined ARM core, directly downstream of the Execute stage.
- Holds the E/M pipeline register and runs data-memory loads and stores over a req/ack handshake that can take several cycles.
- Feeds ALUResultM back to Execute for forwarding and drives the M/W pipeline register for writeback.
- Raises stallM to the hazard unit while a memory access is still outstanding.

Parameters:
- TIMEOUT, 16: number of WAIT cycles with no mem_ack before the access is abandoned. Must be ≥1.
- FAULT_DATA, 32'h0000_0000: value loaded into ReadDataW when an access times out.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. reset=0 at a rising edge clears all state.
- RegWriteE  in  1  register-write enable from Execute.
- MemtoRegE  in  1  load select from Execute (1 = load).
- MemWriteE  in  1  store enable from Execute.
- RdE  in  4  destination register from Execute.
- ALUResultE  in  32  address or ALU result from Execute.
- WriteDataE  in  32  store data from Execute.
- RegWriteM  out  1  E/M register copy, for hazard detection.
- RdM  out  4  E/M register copy.
- ALUResultM  out  32  E/M register copy; forwarding source for Execute.
- stallM  out  1  freezes the E/M register and all upstream stages.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  {ALUResultM[31:2], 2'b00}.
- mem_wdata  out  32  store data held in the E/M register.
- mem_rdata  in  32  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  access completes in this cycle.
- RegWriteW  out  1  M/W register output.
- MemtoRegW  out  1  M/W register output.
- RdW  out  4  M/W register output.
- ALUOutW  out  32  M/W register output.
- ReadDataW  out  32  M/W register output.
- mem_fault  out  1  sticky; set on timeout.

Behaviour:
- Reset (reset=0 at an edge):
  - E/M and M/W registers cleared; all outputs 0.
  - State IDLE, timeout counter 0, mem_fault 0.
  - mem_req is forced to 0 combinationally in any cycle where reset=0, including in the middle of a WAIT.
- memopM = MemtoRegM | MemWriteM, taken from the E/M register.
- E/M register:
  - Loads the E inputs at each edge where reset=1 and stallM=0.
  - Holds its value while stallM=1.
- Handshake:
  - mem_req = memopM & (state==IDLE | state==WAIT) & reset.
  - mem_we = MemWriteM.
  - mem_addr and mem_wdata stay stable while mem_req=1.
- Completion:
  - An access completes in a cycle with mem_req=1 and mem_ack=1 (ok), or on timeout.
  - stallM = memopM & ~complete. Execute-only instructions never stall.
- FSM:
  - IDLE: if memopM and no ack, go to WAIT with counter=1 and stall. A same-cycle ack means a zero-wait access: no stall, stay in IDLE.
  - WAIT: on ack, go to IDLE. Otherwise, if counter==TIMEOUT, complete as a timeout and go to IDLE. Otherwise increment the counter.
  - Back-to-back memory ops: after a completion the next instruction enters E/M and mem_req stays high without a gap.
- M/W register, at each edge with reset=1:
  - If stallM=1: load a bubble (RegWriteW=0, MemtoRegW=0; data fields are don't-care but are held).
  - Otherwise load RegWriteM, MemtoRegM, RdM and ALUResultM.
  - ReadDataW = mem_rdata on an ok load, FAULT_DATA on a load timeout. It holds otherwise.
- Timeout:
  - Sets mem_fault, which stays at 1 until reset.
  - Forces RegWriteW=0 for the faulting instruction. A store timeout writes nothing.
- Stores never write a register, even if RegWriteM=1.
- Latency: an ok zero-wait access presents its result on the W outputs one edge after the instruction enters E/M; each wait cycle adds one edge.

Test Plan:
1. Reset mid-access:
   - Stimulus: a load sits in WAIT with counter=5 and reset=0 for one edge.
   - Response: mem_req=0 in the reset cycle; afterwards state IDLE, stallM=0, all W outputs 0, mem_fault=0.
2. Zero-wait load:
   - Stimulus: MemtoRegE=1, RegWriteE=1, RdE=3, ALUResultE=0x0000_1006. Next cycle mem_ack=1 with mem_rdata=0xCAFEF00D.
   - Response: mem_addr=0x0000_1004, stallM never asserted. Next edge: RegWriteW=1, MemtoRegW=1, RdW=3, ReadDataW=0xCAFEF00D.
3. Three-wait store:
   - Stimulus: MemWriteE=1, WriteDataE=0x1234_5678, ack arrives on the 4th request cycle.
   - Response: stallM=1 for 3 cycles, E/M frozen and mem_wdata steady; the M/W register loads bubbles; RegWriteW=0 throughout.
4. Back-to-back loads:
   - Stimulus: two loads to 0x100 and 0x104, ack held at 1.
   - Response: mem_req high for 2 consecutive cycles; mem_addr 0x100 then 0x104; no stall.
5. Timeout (TIMEOUT=16):
   - Stimulus: a load to 0x200 with ack held at 0.
   - Response: stallM=1 for 16 cycles, then released; mem_fault=1 and stays at 1; RegWriteW=0; ReadDataW=0.
6. ALU-only instruction:
   - Stimulus: RegWriteE=1, RdE=7, ALUResultE=0x55 while memory-op control bits are 0.
   - Response: mem_req=0, ALUResultM=0x55 after 1 edge, and RegWriteW=1, RdW=7, ALUOutW=0x55 after 2 edges.
